// File: rtl/full_adder_unit.sv
// full_adder_unit: registered WIDTH-bit ripple adder, {cout,sum} = a+b+cin, 1-clk latency.
// Ports: clk, rst (async high), in_valid, a, b, cin -> sum, cout, out_valid, ovf (FULL_ADDER_OVF_EN).
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_d[i]    = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]  = (a[i] & b[i])
                       | (a[i] & carry[i])
                       | (b[i] & carry[i]);
  end

  // Results only load on accepted operands; otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_d;
        cout <= carry[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic ovf_d;

  // Like-signed operands producing an opposite-signed sum.
  assign ovf_d = (a[WIDTH-1] == b[WIDTH-1])
              && (sum_d[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit: checks WIDTH=1 and WIDTH=4 adders against an arithmetic model.
// Directed cases, exhaustive sweeps, random traffic and mid-stream reset.
module tb_full_adder_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       sum1, cout1, ov1;
  logic [3:0] sum4;
  logic       cout4, ov4;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1),
    .a(a1), .b(b1), .cin(c1),
    .sum(sum1), .cout(cout1),
`ifdef FULL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .out_valid(ov1)
  );

  full_adder_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4),
    .a(a4), .b(b4), .cin(c4),
    .sum(sum4), .cout(cout4),
`ifdef FULL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .out_valid(ov4)
  );

  // Signed value of a w-bit two's complement pattern.
  function automatic int sval(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic logic sovf(input int x, input int y,
                                input int c, input int w);
    int s;
    s = sval(x, w) + sval(y, w) + c;
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  // Reference model: plain integer arithmetic, results held when idle.
  int   m1_sum, m1_cout, m4_sum, m4_cout;
  logic m1_val, m4_val, m1_ovf, m4_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_sum <= 0; m1_cout <= 0; m1_val <= 0; m1_ovf <= 0;
      m4_sum <= 0; m4_cout <= 0; m4_val <= 0; m4_ovf <= 0;
    end else begin
      m1_val <= v1;
      m4_val <= v4;
      if (v1) begin
        m1_sum  <= (int'(a1) + int'(b1) + int'(c1)) % 2;
        m1_cout <= (int'(a1) + int'(b1) + int'(c1)) / 2;
        m1_ovf  <= sovf(int'(a1), int'(b1), int'(c1), 1);
      end
      if (v4) begin
        m4_sum  <= (int'(a4) + int'(b4) + int'(c4)) % 16;
        m4_cout <= (int'(a4) + int'(b4) + int'(c4)) / 16;
        m4_ovf  <= sovf(int'(a4), int'(b4), int'(c4), 4);
      end
    end
  end

  task automatic cmp(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag);
    cmp({tag, ".sum"}, int'(sum1), m1_sum);
    cmp({tag, ".cout"}, int'(cout1), m1_cout);
    cmp({tag, ".vld"}, int'(ov1), int'(m1_val));
`ifdef FULL_ADDER_OVF_EN
    cmp({tag, ".ovf"}, int'(ovf1), int'(m1_ovf));
`endif
  endtask

  task automatic check4(input string tag);
    cmp({tag, ".sum"}, int'(sum4), m4_sum);
    cmp({tag, ".cout"}, int'(cout4), m4_cout);
    cmp({tag, ".vld"}, int'(ov4), int'(m4_val));
`ifdef FULL_ADDER_OVF_EN
    cmp({tag, ".ovf"}, int'(ovf4), int'(m4_ovf));
`endif
  endtask

  // Drive at the falling edge, result checked at the next falling edge.
  task automatic drive1(input logic a, input logic b,
                        input logic c, input logic v);
    a1 = a; b1 = b; c1 = c; v1 = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic v);
    a4 = a; b4 = b; c4 = c; v4 = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] abc;
    logic [3:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    cmp("rst.sum4", int'(sum4), 0);
    cmp("rst.cout4", int'(cout4), 0);
    cmp("rst.vld4", int'(ov4), 0);
    cmp("rst.sum1", int'(sum1), 0);
    cmp("rst.vld1", int'(ov1), 0);
    rst = 1'b0;

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      drive1(abc[2], abc[1], abc[0], 1'b1);
      check1("w1");
      cmp("w1.sum_tt", int'(sum1), int'(^abc));
      cmp("w1.cout_tt", int'(cout1),
          int'((abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0])));
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    check1("w1.idle");

    // Subtraction via inverted B
    drive4(4'b0101, ~4'b0011, 1'b1, 1'b1);
    check4("sub1");
    cmp("sub1.k_sum", int'(sum4), 2);
    cmp("sub1.k_cout", int'(cout4), 1);
    drive4(4'b0011, ~4'b0101, 1'b1, 1'b1);
    check4("sub2");
    cmp("sub2.k_sum", int'(sum4), 14);
    cmp("sub2.k_cout", int'(cout4), 0);

    // Wrap then idle hold
    drive4(4'hF, 4'hF, 1'b1, 1'b1);
    cmp("wrap.k_sum", int'(sum4), 15);
    cmp("wrap.k_cout", int'(cout4), 1);
    cmp("wrap.k_vld", int'(ov4), 1);
    for (int i = 0; i < 3; i++) begin
      drive4(4'h0, 4'h0, 1'b0, 1'b0);
      check4("hold");
      cmp("hold.k_sum", int'(sum4), 15);
      cmp("hold.k_cout", int'(cout4), 1);
      cmp("hold.k_vld", int'(ov4), 0);
    end
    drive4(4'h0, 4'h0, 1'b0, 1'b1);
    cmp("zero.k_sum", int'(sum4), 0);
    cmp("zero.k_cout", int'(cout4), 0);

`ifdef FULL_ADDER_OVF_EN
    drive4(4'b0111, 4'b0001, 1'b0, 1'b1);
    cmp("ovf1.k_sum", int'(sum4), 8);
    cmp("ovf1.k_ovf", int'(ovf4), 1);
    drive4(4'b1000, 4'b1111, 1'b0, 1'b1);
    cmp("ovf2.k_sum", int'(sum4), 7);
    cmp("ovf2.k_cout", int'(cout4), 1);
    cmp("ovf2.k_ovf", int'(ovf4), 1);
`endif

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 512; i++) begin
      drive4(4'(i >> 5), 4'(i >> 1), 1'(i), 1'b1);
      check4("sweep");
      cmp("sweep.k_vld", int'(ov4), 1);
    end

    // Random traffic with idle gaps
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      drive4(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) != 0));
      drive1(1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
      check4("rnd4");
      check1("rnd1");
    end

    // Reset mid-stream discards the in-flight operation
    drive4(4'd5, 4'd3, 1'b0, 1'b1);
    cmp("pre.k_sum", int'(sum4), 8);
    a4 = 4'b0111; b4 = 4'b0001; c4 = 1'b0; v4 = 1'b1;
    rst = 1'b1;
    #1;
    cmp("mrst.k_sum", int'(sum4), 0);
    cmp("mrst.k_cout", int'(cout4), 0);
    cmp("mrst.k_vld", int'(ov4), 0);
    @(posedge clk);
    @(negedge clk);
    cmp("mrst2.k_sum", int'(sum4), 0);
    cmp("mrst2.k_vld", int'(ov4), 0);
    check4("mrst2");
    rst = 1'b0;

    // First edge after release accepts normally
    drive4(4'd2, 4'd3, 1'b0, 1'b1);
    cmp("post.k_sum", int'(sum4), 5);
    cmp("post.k_vld", int'(ov4), 1);
    check4("post");
    drive4(4'd0, 4'd0, 1'b0, 1'b0);
    cmp("post2.k_vld", int'(ov4), 0);
    cmp("post2.k_sum", int'(sum4), 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
